// File: rtl/pipeline_idex.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and saturating stall/flush event counters.
module pipeline_idex #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Hold,
    input  logic                Flush,
    input  logic                CntClr,
    input  logic [4:0]          ID_Rs,
    input  logic [4:0]          ID_Rt,
    input  logic [4:0]          ID_Rd,
    input  logic                ID_RegWr,
    input  logic                ID_MemRd,
    input  logic                ID_MemWr,
    input  logic                ID_MemtoReg,
    input  logic                ID_ALUSrc,
    input  logic                ID_RegDst,
    input  logic [3:0]          ID_ALUOp,
    input  logic [31:0]         ID_BusA,
    input  logic [31:0]         ID_BusB,
    input  logic [31:0]         ID_Imm32,
    input  logic [31:0]         ID_PC4,
    output logic [4:0]          IDEX_Rs,
    output logic [4:0]          IDEX_Rt,
    output logic [4:0]          IDEX_Rd,
    output logic                IDEX_RegWr,
    output logic                IDEX_MemRd,
    output logic                IDEX_MemWr,
    output logic                IDEX_MemtoReg,
    output logic                IDEX_ALUSrc,
    output logic                IDEX_RegDst,
    output logic [3:0]          IDEX_ALUOp,
    output logic [31:0]         IDEX_BusA,
    output logic [31:0]         IDEX_BusB,
    output logic [31:0]         IDEX_Imm32,
    output logic [31:0]         IDEX_PC4,
    output logic                IDEX_Valid,
    output logic                Stall,
    output logic                PC_Wr,
    output logic                IFID_Wr,
    output logic [CntWidth-1:0] StallCnt,
    output logic [CntWidth-1:0] FlushCnt
);

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  alu_op;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] imm32;
        logic [31:0] pc4;
        logic        valid;
    } idex_t;

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth - 1){1'b0}}, 1'b1};

    idex_t               id_in;
    idex_t               idex_d, idex_q;
    logic                stall;
    logic                bubble;
    logic [CntWidth-1:0] stall_cnt_d, stall_cnt_q;
    logic [CntWidth-1:0] flush_cnt_d, flush_cnt_q;

    // Load-use hazard against the load sitting in EX; a flush kills the
    // consumer anyway, so it suppresses the stall.
    always_comb begin
        stall = 1'b0;
        if (idex_q.valid && idex_q.mem_rd && (idex_q.rt != 5'd0) && !Flush) begin
            stall = (idex_q.rt == ID_Rs) || (idex_q.rt == ID_Rt);
        end
    end

    assign bubble = Flush || stall;

    always_comb begin
        id_in            = '0;
        id_in.rs         = ID_Rs;
        id_in.rt         = ID_Rt;
        id_in.rd         = ID_Rd;
        id_in.reg_wr     = ID_RegWr;
        id_in.mem_rd     = ID_MemRd;
        id_in.mem_wr     = ID_MemWr;
        id_in.mem_to_reg = ID_MemtoReg;
        id_in.alu_src    = ID_ALUSrc;
        id_in.reg_dst    = ID_RegDst;
        id_in.alu_op     = ID_ALUOp;
        id_in.bus_a      = ID_BusA;
        id_in.bus_b      = ID_BusB;
        id_in.imm32      = ID_Imm32;
        id_in.pc4        = ID_PC4;
        id_in.valid      = 1'b1;
    end

    always_comb begin
        idex_d = idex_q;
        if (!Hold) begin
            idex_d = bubble ? '0 : id_in;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!Hold) begin
            if (CntClr) begin
                stall_cnt_d = '0;
                flush_cnt_d = '0;
            end else begin
                if (Flush && (flush_cnt_q != CntMax)) begin
                    flush_cnt_d = flush_cnt_q + CntOne;
                end
                if (stall && (stall_cnt_q != CntMax)) begin
                    stall_cnt_d = stall_cnt_q + CntOne;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign IDEX_Rs       = idex_q.rs;
    assign IDEX_Rt       = idex_q.rt;
    assign IDEX_Rd       = idex_q.rd;
    assign IDEX_RegWr    = idex_q.reg_wr;
    assign IDEX_MemRd    = idex_q.mem_rd;
    assign IDEX_MemWr    = idex_q.mem_wr;
    assign IDEX_MemtoReg = idex_q.mem_to_reg;
    assign IDEX_ALUSrc   = idex_q.alu_src;
    assign IDEX_RegDst   = idex_q.reg_dst;
    assign IDEX_ALUOp    = idex_q.alu_op;
    assign IDEX_BusA     = idex_q.bus_a;
    assign IDEX_BusB     = idex_q.bus_b;
    assign IDEX_Imm32    = idex_q.imm32;
    assign IDEX_PC4      = idex_q.pc4;
    assign IDEX_Valid    = idex_q.valid;

    assign Stall    = stall;
    assign PC_Wr    = !(stall || Hold);
    assign IFID_Wr  = !(stall || Hold);
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

    // A stall inserts a bubble, and a bubble can never trigger another stall.
    a_stall_one_cycle: assert property (@(posedge clk) disable iff (!reset)
        (stall && !Hold) |=> (!IDEX_Valid && !stall));

    a_stall_cnt_sat: assert property (@(posedge clk) disable iff (!reset)
        (stall_cnt_q == CntMax && !CntClr) |=> (stall_cnt_q == CntMax));

    a_flush_cnt_sat: assert property (@(posedge clk) disable iff (!reset)
        (flush_cnt_q == CntMax && !CntClr) |=> (flush_cnt_q == CntMax));

endmodule
